alb_mss_mem_ibp_fifo_buf: RTL

Parametrised IBP slice buffer for the MSS memory testbench path. It sits between an IBP master and the memory model. It buffers the command, write-data and read-response channels in FIFOs of configurable depth. It also enforces the IBP ordering rules that write data never leads its command and that outstanding write commands are bounded. This is the successor to the single-entry cmd/wr buffer: it adds depth, a read-response channel, saturation-safe outstanding tracking and status outputs.

---
 rtl/alb_mss_mem_ibp_pkg.sv | 15 +
 rtl/alb_mss_mem_ibp_fifo.sv | 56 +++++
 rtl/alb_mss_mem_ibp_fifo_buf.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alb_mss_mem_ibp_pkg.sv
// rtl/alb_mss_mem_ibp_pkg.sv - shared widths and helpers for the IBP slice buffer
package alb_mss_mem_ibp_pkg;

  // read + wrap + data_size + burst_size + prot + cache + lock + excl
  localparam int IBP_CMD_CTRL_W = 17;

  function automatic int ibp_cmd_w(input int a_w, input int id_w, input int u_w, input int rg_w);
    return a_w + id_w + u_w + rg_w + IBP_CMD_CTRL_W;
  endfunction

  function automatic int ibp_wr_w(input int d_w);
    return d_w + d_w / 8 + 1;
  endfunction

endpackage

// File: rtl/alb_mss_mem_ibp_fifo.sv
// rtl/alb_mss_mem_ibp_fifo.sv - valid/accept FIFO with zero-latency bypass when empty
module alb_mss_mem_ibp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_accept,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_accept,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             store;
  logic             drop;

  assign empty     = (count == '0);
  assign in_accept = (count != FULL_CNT);
  assign push      = in_valid & in_accept;
  assign out_valid = empty ? in_valid : 1'b1;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign pop       = out_valid & out_accept;
  // A push into an empty FIFO that is popped in the same cycle never lands in storage.
  assign store     = push & ~(empty & pop);
  assign drop      = pop & ~empty;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (drop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(store) - CW'(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/alb_mss_mem_ibp_fifo_buf.sv
// rtl/alb_mss_mem_ibp_fifo_buf.sv - IBP cmd/wr/rd slice buffer with write ordering and outstanding-write bound
// Optional buffered read-response channel: ALB_MSS_MEM_IBP_BUF_RD_EN.
module alb_mss_mem_ibp_fifo_buf
  import alb_mss_mem_ibp_pkg::*;
#(
  parameter int id_w      = 5,
  parameter int rg_w      = 1,
  parameter int u_w       = 1,
  parameter int a_w       = 32,
  parameter int d_w       = 32,
  parameter int CMD_DEPTH = 2,
  parameter int WR_DEPTH  = 4,
  parameter int RD_DEPTH  = 4,
  parameter int MAX_WCMD  = 4
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            i_ibp_cmd_valid,
  output logic                            i_ibp_cmd_accept,
  input  logic                            i_ibp_cmd_read,
  input  logic [a_w-1:0]                  i_ibp_cmd_addr,
  input  logic                            i_ibp_cmd_wrap,
  input  logic [2:0]                      i_ibp_cmd_data_size,
  input  logic [3:0]                      i_ibp_cmd_burst_size,
  input  logic [1:0]                      i_ibp_cmd_prot,
  input  logic [3:0]                      i_ibp_cmd_cache,
  input  logic                            i_ibp_cmd_lock,
  input  logic                            i_ibp_cmd_excl,
  input  logic [id_w-1:0]                 i_ibp_cmd_id,
  input  logic [u_w-1:0]                  i_ibp_cmd_user,
  input  logic [rg_w-1:0]                 i_ibp_cmd_region,
  input  logic                            i_ibp_wr_valid,
  output logic                            i_ibp_wr_accept,
  input  logic [d_w-1:0]                  i_ibp_wr_data,
  input  logic [d_w/8-1:0]                i_ibp_wr_mask,
  input  logic                            i_ibp_wr_last,
  output logic                            o_ibp_cmd_valid,
  input  logic                            o_ibp_cmd_accept,
  output logic                            o_ibp_cmd_read,
  output logic [a_w-1:0]                  o_ibp_cmd_addr,
  output logic                            o_ibp_cmd_wrap,
  output logic [2:0]                      o_ibp_cmd_data_size,
  output logic [3:0]                      o_ibp_cmd_burst_size,
  output logic [1:0]                      o_ibp_cmd_prot,
  output logic [3:0]                      o_ibp_cmd_cache,
  output logic                            o_ibp_cmd_lock,
  output logic                            o_ibp_cmd_excl,
  output logic [id_w-1:0]                 o_ibp_cmd_id,
  output logic [u_w-1:0]                  o_ibp_cmd_user,
  output logic [rg_w-1:0]                 o_ibp_cmd_region,
  output logic                            o_ibp_wr_valid,
  input  logic                            o_ibp_wr_accept,
  output logic [d_w-1:0]                  o_ibp_wr_data,
  output logic [d_w/8-1:0]                o_ibp_wr_mask,
  output logic                            o_ibp_wr_last,
  output logic                            i_ibp_rd_valid,
  input  logic                            i_ibp_rd_accept,
  output logic [d_w-1:0]                  i_ibp_rd_data,
  output logic                            i_ibp_rd_last,
  output logic                            i_ibp_rd_err,
  input  logic                            o_ibp_rd_valid,
  output logic                            o_ibp_rd_accept,
  input  logic [d_w-1:0]                  o_ibp_rd_data,
  input  logic                            o_ibp_rd_last,
  input  logic                            o_ibp_rd_err,
  output logic [$clog2(MAX_WCMD+1)-1:0]   wcmd_pending,
  output logic                            buf_idle
);
  localparam int CMD_W = ibp_cmd_w(a_w, id_w, u_w, rg_w);
  localparam int WR_W  = ibp_wr_w(d_w);
  localparam int PCW   = $clog2(MAX_WCMD + 1);
  localparam logic [PCW-1:0] WCMD_MAX = PCW'(MAX_WCMD);

  if (CMD_DEPTH < 1 || WR_DEPTH < 1 || RD_DEPTH < 1 || MAX_WCMD < 1 || d_w < 8 || (d_w % 8) != 0)
  begin : g_bad_params
    $error("alb_mss_mem_ibp_fifo_buf: illegal parameter set");
  end

  logic [CMD_W-1:0] cmd_in, cmd_out;
  logic [WR_W-1:0]  wr_in, wr_out;
  logic [PCW-1:0]   pending;
  logic cmd_not_full, wr_not_full;
  logic cmd_empty, wr_empty, rd_empty;
  logic cmd_block, inc, dec, wr_ok;

  assign cmd_in = {i_ibp_cmd_read, i_ibp_cmd_wrap, i_ibp_cmd_data_size, i_ibp_cmd_burst_size,
                   i_ibp_cmd_prot, i_ibp_cmd_cache, i_ibp_cmd_lock, i_ibp_cmd_excl,
                   i_ibp_cmd_id, i_ibp_cmd_user, i_ibp_cmd_region, i_ibp_cmd_addr};
  assign {o_ibp_cmd_read, o_ibp_cmd_wrap, o_ibp_cmd_data_size, o_ibp_cmd_burst_size,
          o_ibp_cmd_prot, o_ibp_cmd_cache, o_ibp_cmd_lock, o_ibp_cmd_excl,
          o_ibp_cmd_id, o_ibp_cmd_user, o_ibp_cmd_region, o_ibp_cmd_addr} = cmd_out;
  assign wr_in = {i_ibp_wr_data, i_ibp_wr_mask, i_ibp_wr_last};
  assign {o_ibp_wr_data, o_ibp_wr_mask, o_ibp_wr_last} = wr_out;

  // Saturation only holds back writes, so the counter can never wrap.
  assign cmd_block        = ~i_ibp_cmd_read & (pending == WCMD_MAX);
  assign i_ibp_cmd_accept = cmd_not_full & ~cmd_block;
  assign inc              = i_ibp_cmd_valid & i_ibp_cmd_accept & ~i_ibp_cmd_read;
  assign wr_ok            = (pending != '0) | inc;
  assign i_ibp_wr_accept  = wr_not_full & wr_ok;
  assign dec              = i_ibp_wr_valid & i_ibp_wr_accept & i_ibp_wr_last;
  assign wcmd_pending     = pending;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pending <= '0;
    end else if (inc & ~dec) begin
      pending <= pending + PCW'(1);
    end else if (dec & ~inc) begin
      pending <= pending - PCW'(1);
    end
  end

  alb_mss_mem_ibp_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(CMD_W)) u_cmd_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (i_ibp_cmd_valid & ~cmd_block),
    .in_accept  (cmd_not_full),
    .in_data    (cmd_in),
    .out_valid  (o_ibp_cmd_valid),
    .out_accept (o_ibp_cmd_accept),
    .out_data   (cmd_out),
    .empty      (cmd_empty)
  );

  alb_mss_mem_ibp_fifo #(.DEPTH(WR_DEPTH), .WIDTH(WR_W)) u_wr_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (i_ibp_wr_valid & wr_ok),
    .in_accept  (wr_not_full),
    .in_data    (wr_in),
    .out_valid  (o_ibp_wr_valid),
    .out_accept (o_ibp_wr_accept),
    .out_data   (wr_out),
    .empty      (wr_empty)
  );

`ifdef ALB_MSS_MEM_IBP_BUF_RD_EN
  alb_mss_mem_ibp_fifo #(.DEPTH(RD_DEPTH), .WIDTH(d_w + 2)) u_rd_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (o_ibp_rd_valid),
    .in_accept  (o_ibp_rd_accept),
    .in_data    ({o_ibp_rd_data, o_ibp_rd_last, o_ibp_rd_err}),
    .out_valid  (i_ibp_rd_valid),
    .out_accept (i_ibp_rd_accept),
    .out_data   ({i_ibp_rd_data, i_ibp_rd_last, i_ibp_rd_err}),
    .empty      (rd_empty)
  );
`else
  assign i_ibp_rd_valid  = o_ibp_rd_valid;
  assign i_ibp_rd_data   = o_ibp_rd_data;
  assign i_ibp_rd_last   = o_ibp_rd_last;
  assign i_ibp_rd_err    = o_ibp_rd_err;
  assign o_ibp_rd_accept = i_ibp_rd_accept;
  assign rd_empty        = 1'b1;
`endif

  assign buf_idle = cmd_empty & wr_empty & rd_empty & (pending == '0);

endmodule
